// File: rtl/ct_arb_pkg.sv
// Shared types and helpers for the counter load arbiter.
//   arb_state_t : arbiter FSM states (IDLE, LOAD, GAP)
//   id_width()  : width of a requester index for a given requester count
package ct_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // A single requester still gets a 1-bit index so ports never collapse to zero width.
    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/ct_rr_picker.sv
// Combinational round-robin picker.
//   valid  : request vector
//   ptr    : index with highest priority this round
//   any    : at least one request is set
//   winner : first set index at or after ptr, wrapping modulo NUM_REQ
module ct_rr_picker
    import ct_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    int idx;

    // Scan offsets from farthest to nearest; the last hit written is the
    // nearest one at or after ptr, which gives round-robin priority.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[ID_W'(idx)]) begin
                any    = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ct_load_arbiter.sv
// Round-robin arbiter sharing a counter's parallel-load port.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester load request
//   req_data  : packed load values, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready : one-hot, one-cycle acknowledge to the winner
//   ld, data  : one-cycle load strobe and load value to the counter
//   busy      : arbiter is in LOAD or GAP
//   grant_id  : index of the last granted requester
// Handshake: a requester holds req_valid/req_data until req_ready; the
// transfer completes in the cycle where both are high. Requests are only
// sampled in IDLE, so a winner still holding valid is never double-granted.
module ct_load_arbiter
    import ct_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int LD_GAP     = 2,
    localparam int ID_W      = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          ld,
    output logic [DATA_WIDTH-1:0]         data,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    localparam int GW = (LD_GAP > 0) ? $clog2(LD_GAP + 1) : 1;

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        ptr_q;
    logic [GW-1:0]          gap_q;
    logic                   any;
    logic [ID_W-1:0]        winner;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   ld_d;
    logic [NUM_REQ-1:0]     ready_d;
    logic                   busy_d;

    ct_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .valid  (req_valid),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ID_W'(i)) begin
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (any) state_d = LOAD;
            LOAD: state_d = (LD_GAP > 0) ? GAP : IDLE;
            GAP:  if (gap_q <= GW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode; results are registered below so every port is a flop.
    always_comb begin
        ld_d    = (state_q == IDLE) && any;
        ready_d = ld_d ? (NUM_REQ'(1) << winner) : '0;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld        <= 1'b0;
            req_ready <= '0;
            busy      <= 1'b0;
            data      <= '0;
            grant_id  <= '0;
            ptr_q     <= '0;
            gap_q     <= '0;
        end else begin
            ld        <= ld_d;
            req_ready <= ready_d;
            busy      <= busy_d;
            if (ld_d) begin
                // Value captured at the sampling edge; later req_data changes are ignored.
                data     <= sel_data;
                grant_id <= winner;
                ptr_q    <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            end
            // Counter is loaded during LOAD so GAP lasts exactly LD_GAP cycles.
            if (state_q == LOAD) begin
                gap_q <= GW'(LD_GAP);
            end else if (state_q == GAP && gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ct_load_arbiter.sv
// Self-checking bench for ct_load_arbiter: a cycle-level reference model
// (grant timing from a busy-window count, round-robin from a modulo scan)
// checks every output every cycle, plus directed scenario checks.
module tb_ct_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        ld;
  logic [7:0]  data;
  logic        busy;
  logic [1:0]  grant_id;

  logic [1:0]  z_valid;
  logic [15:0] z_data;
  logic [1:0]  z_ready;
  logic        z_ld;
  logic [7:0]  z_out;
  logic        z_busy;
  logic [0:0]  z_gid;

  always #5 clk = ~clk;

  ct_load_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .LD_GAP(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ld(ld), .data(data), .busy(busy), .grant_id(grant_id)
  );

  ct_load_arbiter #(.DATA_WIDTH(8), .NUM_REQ(2), .LD_GAP(0)) u_z (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_data(z_data),
    .req_ready(z_ready), .ld(z_ld), .data(z_out), .busy(z_busy), .grant_id(z_gid)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  int         m_ptr;
  int         m_wait;   // cycles the arbiter stays busy, counted from its grant
  logic       e_ld;
  logic [3:0] e_ready;
  logic [7:0] e_data;
  int         e_gid;
  logic       e_busy;

  logic [3:0] rereq;
  logic [3:0] pend_drop;
  logic [7:0] exp_q[$];
  int         gid_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int w;
    if (rst) begin
      m_ptr = 0; m_wait = 0;
      e_ld = 0; e_ready = 0; e_data = 0; e_gid = 0; e_busy = 0;
    end else if (m_wait == 0 && req_valid != 4'b0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      end
      e_ld = 1;
      e_ready = 4'b0001 << w;
      e_data = req_data[w*8 +: 8];
      e_gid = w;
      m_ptr = (w + 1) % 4;
      m_wait = 1 + 2;
      e_busy = 1;
    end else begin
      e_ld = 0;
      e_ready = 0;
      if (m_wait > 0) m_wait--;
      e_busy = (m_wait > 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ld", {31'b0, ld}, {31'b0, e_ld});
    chk("data", {24'b0, data}, {24'b0, e_data});
    chk("req_ready", {28'b0, req_ready}, {28'b0, e_ready});
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("grant_id", {30'b0, grant_id}, e_gid);
  endtask

  // Requester behaviour: hold until acknowledged, then drop (or re-request
  // with fresh data) on the following cycle.
  task automatic service();
    for (int i = 0; i < 4; i++) begin
      if (pend_drop[i]) begin
        pend_drop[i] = 1'b0;
        if (rereq[i]) req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
        else req_valid[i] = 1'b0;
      end
      if (req_valid[i] && req_ready[i]) pend_drop[i] = 1'b1;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      service();
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = 32'h44332211;
    rereq = 4'h0;
    pend_drop = 4'h0;
    z_valid = 2'b00;
    z_data = 16'hB1A0;

    // reset held with every request pending
    for (int i = 0; i < 3; i++) tick();

    // full contention on main DUT, back-to-back contention on the gap-free build
    rst = 1'b0;
    z_valid = 2'b11;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int t = 0; t < 20; t++) begin
      tick();
      if (t < 8) begin
        chk("z_ld", {31'b0, z_ld}, {31'b0, (t % 2 == 0)});
        chk("z_busy", {31'b0, z_busy}, {31'b0, (t % 2 == 0)});
        if (t % 2 == 0) begin
          chk("z_data", {24'b0, z_out}, ((t / 2) % 2 == 1) ? 32'hB1 : 32'hA0);
          chk("z_gid", {31'b0, z_gid}, (t / 2) % 2);
          chk("z_ready", {30'b0, z_ready}, ((t / 2) % 2 == 1) ? 32'h2 : 32'h1);
        end
      end
      if (t == 7) z_valid = 2'b00;
      if (ld) begin
        if (exp_q.size() > 0) chk("contention_order", {24'b0, data}, {24'b0, exp_q.pop_front()});
        else chk("contention_extra_ld", 32'h1, 32'h0);
      end
      service();
    end
    chk("contention_left", exp_q.size(), 0);
    chk("contention_hold", {24'b0, data}, 32'h44);

    // single request
    settle(4);
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'h5A;
    tick();
    chk("single_ld", {31'b0, ld}, 32'h1);
    chk("single_data", {24'b0, data}, 32'h5A);
    chk("single_ready", {28'b0, req_ready}, 32'h4);
    chk("single_gid", {30'b0, grant_id}, 32'h2);
    service();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("single_gap_ld", {31'b0, ld}, 32'h0);
      chk("single_gap_busy", {31'b0, busy}, 32'h1);
      service();
    end
    tick();
    chk("single_idle_busy", {31'b0, busy}, 32'h0);
    chk("single_hold", {24'b0, data}, 32'h5A);
    service();

    // fairness: two continuous requesters
    settle(4);
    rereq = 4'b1001;
    req_valid = 4'b1001;
    gid_q.delete();
    for (int t = 0; t < 16; t++) begin
      tick();
      if (ld) gid_q.push_back(int'(grant_id));
      service();
    end
    chk("fair_count", gid_q.size(), 4);
    for (int n = 1; n < gid_q.size(); n++) begin
      chk("fair_alternate", {31'b0, ((gid_q[n] == 0 || gid_q[n] == 3) && gid_q[n] != gid_q[n-1])}, 32'h1);
    end
    rereq = 4'b0000;
    settle(8);

    // reset during the first GAP cycle with requests pending
    req_valid[2] = 1'b1;
    req_data[23:16] = 8'hC2;
    tick();
    chk("rg_ld", {31'b0, ld}, 32'h1);
    chk("rg_gid", {30'b0, grant_id}, 32'h2);
    service();
    req_valid[1] = 1'b1;
    req_data[15:8] = 8'h77;
    req_valid[3] = 1'b1;
    req_data[31:24] = 8'hD3;
    tick();
    service();
    rst = 1'b1;
    tick();
    chk("rg_busy", {31'b0, busy}, 32'h0);
    chk("rg_data", {24'b0, data}, 32'h0);
    service();
    rst = 1'b0;
    tick();
    chk("rg_regrant_ld", {31'b0, ld}, 32'h1);
    chk("rg_regrant_gid", {30'b0, grant_id}, 32'h1);
    chk("rg_regrant_data", {24'b0, data}, 32'h77);
    service();
    settle(10);

    // randomized traffic with occasional resets
    for (int t = 0; t < 400; t++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && !pend_drop[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_data[i*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
      tick();
      service();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
